// File: rtl/status_event_logger.sv
// Status-change logger: every change on the status bus is stamped with a free-running
// cycle count and queued in a first-word-fall-through FIFO, read out over valid/ready.
module status_event_logger #(
  parameter int STATUS_W = 1,
  parameter int TS_W     = 16,
  parameter int DEPTH    = 8,
  parameter int AW       = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [STATUS_W-1:0]      status,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [TS_W+STATUS_W-1:0] rd_data,
  output logic [AW:0]              count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int EW = TS_W + STATUS_W;

  logic [TS_W-1:0]          ts;
  logic [STATUS_W-1:0]      status_q;
  logic [DEPTH-1:0][EW-1:0] mem;
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic                     hit, pop, full, wr_en, drop;

  assign hit   = enable && (status != status_q);
  assign full  = (count == (AW+1)'(DEPTH));
  assign pop   = rd_valid && rd_ready;
  // A pop frees the head slot at the same edge, so a full FIFO can still take the event.
  assign wr_en = hit && (!full || pop);
  assign drop  = hit && full && !pop;

  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {ts, status};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts       <= '0;
      status_q <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      ts       <= ts + TS_W'(1);
      status_q <= status;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (clear) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
      // Clear wins first, then a same-cycle drop is counted on top of the zeroed value.
      if (drop) begin
        overflow <= 1'b1;
        if (clear)                 drop_cnt <= 8'd1;
        else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_status_event_logger.sv
// Bench for status_event_logger: directed scenarios plus random traffic, checked against
// a queue-based reference model of the event log.
module tb_status_event_logger;

  localparam int SW = 1, TW = 16, DEPTH = 8, AW = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [SW-1:0]     status = '0;
  logic              enable = 1'b0, clear = 1'b0, rd_ready = 1'b0;
  logic              rd_valid;
  logic [TW+SW-1:0]  rd_data;
  logic [AW:0]       count;
  logic              overflow;
  logic [7:0]        drop_cnt;

  status_event_logger #(.STATUS_W(SW), .TS_W(TW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .status(status), .enable(enable), .clear(clear),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .count(count),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // reference model
  logic [TW+SW-1:0] q[$];
  logic [TW-1:0]    m_ts;
  logic [SW-1:0]    m_sq;
  logic             m_ovf;
  int               m_drop;

  int n_assert = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
    check("count", 32'(count), 32'(q.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    check("ts", 32'(dut.ts), 32'(m_ts));
    if (q.size() != 0) check("rd_data", 32'(rd_data), 32'(q[0]));
  endtask

  // Called at a negedge; drives inputs, advances through one rising edge, checks, returns at next negedge.
  task automatic step(input logic [SW-1:0] st, input logic en, input logic clr, input logic rdy);
    logic ev, was_full, popm;
    status = st; enable = en; clear = clr; rd_ready = rdy;
    @(posedge clk);
    ev       = en && (st != m_sq);
    was_full = (q.size() == DEPTH);
    popm     = (q.size() != 0) && rdy;
    if (clr) begin m_ovf = 1'b0; m_drop = 0; end
    if (popm) void'(q.pop_front());
    if (ev) begin
      if (!was_full || popm) q.push_back({m_ts, st});
      else begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
    m_sq = st;
    m_ts = m_ts + 16'd1;
    #1 check_model();
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    q.delete(); m_ts = '0; m_sq = '0; m_ovf = 1'b0; m_drop = 0;
    status = '0; enable = 1'b1; clear = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [SW-1:0]    cur;
    logic [TW+SW-1:0] exp_e;

    @(negedge clk);
    // 1: idle after reset
    do_reset();
    repeat (100) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("t1_ts100", 32'(dut.ts), 32'd100);
    check("t1_count", 32'(count), 32'd0);

    // 2: single event at ts=20, then pop
    do_reset();
    repeat (20) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t2_data", 32'(rd_data), 32'({16'd20, 1'b1}));
    check("t2_count1", 32'(count), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("t2_valid0", 32'(rd_valid), 32'd0);

    // 3: overflow by 2, drain in order
    do_reset();
    repeat (30) step(1'b0, 1'b1, 1'b0, 1'b0);
    cur = '0;
    for (int i = 0; i < 10; i++) begin cur = ~cur; step(cur, 1'b1, 1'b0, 1'b0); end
    check("t3_count8", 32'(count), 32'd8);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_drop2", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 8; i++) begin
      exp_e = {16'(30 + i), (i % 2 == 0) ? 1'b1 : 1'b0};
      check("t3_drain", 32'(rd_data), 32'(exp_e));
      step(cur, 1'b1, 1'b0, 1'b1);
    end
    check("t3_empty", 32'(count), 32'd0);

    // 4: full with drop+clear, event+pop, clear alone
    do_reset();
    cur = '0;
    for (int i = 0; i < 9; i++) begin cur = ~cur; step(cur, 1'b1, 1'b0, 1'b0); end
    cur = ~cur; step(cur, 1'b1, 1'b1, 1'b0);
    check("t4_clrdrop_ovf", 32'(overflow), 32'd1);
    check("t4_clrdrop_cnt", 32'(drop_cnt), 32'd1);
    cur = ~cur; exp_e = {m_ts, cur}; step(cur, 1'b1, 1'b0, 1'b1);
    check("t4_fullpop_count", 32'(count), 32'd8);
    check("t4_fullpop_drop", 32'(drop_cnt), 32'd1);
    step(cur, 1'b1, 1'b1, 1'b0);
    check("t4_clear_ovf", 32'(overflow), 32'd0);
    check("t4_clear_drop", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("t4_last", 32'(rd_data), 32'(exp_e));
      step(cur, 1'b1, 1'b0, 1'b1);
    end

    // 5: disabled changes are lost, re-enable is silent
    do_reset();
    cur = '0;
    for (int i = 0; i < 5; i++) begin cur = ~cur; step(cur, 1'b0, 1'b0, 1'b0); end
    step(cur, 1'b1, 1'b0, 1'b0);
    check("t5_none", 32'(count), 32'd0);
    cur = ~cur; step(cur, 1'b1, 1'b0, 1'b0);
    check("t5_one", 32'(count), 32'd1);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(SW'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 4));

    // 6: async reset with entries queued, then timestamp wrap
    do_reset();
    cur = '0;
    for (int i = 0; i < 9; i++) begin cur = ~cur; step(cur, 1'b1, 1'b0, 1'b0); end
    repeat (5) step(cur, 1'b1, 1'b0, 1'b1);
    check("t6_pre_count", 32'(count), 32'd3);
    check("t6_pre_ovf", 32'(overflow), 32'd1);
    do_reset();
    repeat (65535) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("t6_wrap_hi", 32'(rd_data), 32'({16'hFFFF, 1'b1}));
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("t6_wrap_lo", 32'(rd_data), 32'({16'h0000, 1'b0}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
